// File: rtl/dat_pkg.sv
// Shared definitions for the DAT task-RAM sequencer: default widths,
// command opcodes and the engine state encoding.
package dat_pkg;

    localparam int DAT_TASK_W = 12;
    localparam int DAT_SLOT_W = 3;
    localparam int DAT_DATA_W = 16;

    localparam logic [1:0] OP_COPY  = 2'b00;
    localparam logic [1:0] OP_FILL  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_RD   = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } dat_state_e;

endpackage

// File: rtl/dat_slot_counter.sv
// Slot index counter for the DAT sequencer: synchronous clear, count enable,
// terminal-count flag at the last slot of a task.
module dat_slot_counter #(
    parameter int SLOT_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    output logic [SLOT_W-1:0] count,
    output logic              tc
);

    logic [SLOT_W-1:0] count_r;

    // Slot counter register; natural wrap takes the last slot back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {SLOT_W{1'b0}};
        end else if (clr) begin
            count_r <= {SLOT_W{1'b0}};
        end else if (en) begin
            count_r <= count_r + {{(SLOT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign tc    = (count_r == {SLOT_W{1'b1}});

endmodule

// File: rtl/dat_sequencer.sv
// DAT task-RAM sequencer: identity-maps task 0 after reset, then runs CPU
// commanded copy / identity-fill / clear over one task's slots, stealing idle DAT cycles.
module dat_sequencer
    import dat_pkg::*;
#(
    parameter int TASK_W = DAT_TASK_W,
    parameter int SLOT_W = DAT_SLOT_W,
    parameter int DATA_W = DAT_DATA_W
) (
    input  logic                     e,
    input  logic                     _reset,
    input  logic                     cpu_req,
    input  logic                     cmd_start,
    input  logic [1:0]               cmd_op,
    input  logic [TASK_W-1:0]        src_task,
    input  logic [TASK_W-1:0]        dst_task,
    input  logic [DATA_W-1:0]        dat_rdata,
    output logic                     eng_sel,
    output logic [TASK_W+SLOT_W-1:0] eng_addr,
    output logic [DATA_W-1:0]        eng_wdata,
    output logic                     eng_we,
    output logic                     busy,
    output logic                     done
);

    dat_state_e          state_r;
    dat_state_e          next_s;
    logic [TASK_W-1:0]   src_r;
    logic [TASK_W-1:0]   dst_r;
    logic [1:0]          op_r;
    logic [DATA_W-1:0]   hold_r;

    logic [SLOT_W-1:0]   slot_s;
    logic                slot_tc_s;
    logic                slot_clr_s;
    logic                slot_en_s;
    logic                hold_ld_s;
    logic                cmd_ld_s;
    logic                grant_s;
    logic                own_state_s;
    logic                wr_state_s;
    logic [DATA_W-1:0]   slot_ext_s;

    // The CPU always wins the RAM; a cycle it uses is a full stall for the engine.
    assign grant_s    = ~cpu_req;
    assign slot_ext_s = {{(DATA_W-SLOT_W){1'b0}}, slot_s};

    dat_slot_counter #(
        .SLOT_W (SLOT_W)
    ) u_slot_counter (
        .clk   (e),
        .rst_n (_reset),
        .clr   (slot_clr_s),
        .en    (slot_en_s),
        .count (slot_s),
        .tc    (slot_tc_s)
    );

    // Engine state register.
    always_ff @(posedge e or negedge _reset) begin
        if (!_reset) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= next_s;
        end
    end

    // Command latch and copy holding register.
    always_ff @(posedge e or negedge _reset) begin
        if (!_reset) begin
            src_r  <= {TASK_W{1'b0}};
            dst_r  <= {TASK_W{1'b0}};
            op_r   <= OP_COPY;
            hold_r <= {DATA_W{1'b0}};
        end else begin
            if (cmd_ld_s) begin
                src_r <= src_task;
                dst_r <= dst_task;
                op_r  <= cmd_op;
            end
            if (hold_ld_s) begin
                hold_r <= dat_rdata;
            end
        end
    end

    // Next-state and datapath control.
    always_comb begin
        next_s     = state_r;
        slot_clr_s = 1'b0;
        slot_en_s  = 1'b0;
        hold_ld_s  = 1'b0;
        cmd_ld_s   = 1'b0;
        case (state_r)
            ST_INIT: begin
                if (grant_s) begin
                    slot_en_s = 1'b1;
                    if (slot_tc_s) begin
                        next_s = ST_IDLE;
                    end else begin
                        next_s = ST_INIT;
                    end
                end else begin
                    next_s = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (cmd_start && (cmd_op != OP_RSVD)) begin
                    cmd_ld_s   = 1'b1;
                    slot_clr_s = 1'b1;
                    if (cmd_op == OP_COPY) begin
                        next_s = ST_RD;
                    end else begin
                        next_s = ST_WR;
                    end
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (grant_s) begin
                    hold_ld_s = 1'b1;
                    next_s    = ST_WR;
                end else begin
                    next_s = ST_RD;
                end
            end
            ST_WR: begin
                if (grant_s) begin
                    slot_en_s = 1'b1;
                    if (slot_tc_s) begin
                        next_s = ST_DONE;
                    end else if (op_r == OP_COPY) begin
                        next_s = ST_RD;
                    end else begin
                        next_s = ST_WR;
                    end
                end else begin
                    next_s = ST_WR;
                end
            end
            ST_DONE: begin
                next_s = ST_IDLE;
            end
            default: begin
                next_s = ST_INIT;
            end
        endcase
    end

    // DAT address / write data and which states may drive the RAM.
    always_comb begin
        eng_addr    = {dst_r, slot_s};
        eng_wdata   = {DATA_W{1'b0}};
        own_state_s = 1'b0;
        wr_state_s  = 1'b0;
        case (state_r)
            ST_INIT: begin
                eng_addr    = {{TASK_W{1'b0}}, slot_s};
                eng_wdata   = slot_ext_s;
                own_state_s = 1'b1;
                wr_state_s  = 1'b1;
            end
            ST_RD: begin
                eng_addr    = {src_r, slot_s};
                own_state_s = 1'b1;
            end
            ST_WR: begin
                eng_addr    = {dst_r, slot_s};
                own_state_s = 1'b1;
                wr_state_s  = 1'b1;
                case (op_r)
                    OP_COPY:  eng_wdata = hold_r;
                    OP_FILL:  eng_wdata = slot_ext_s;
                    OP_CLEAR: eng_wdata = {DATA_W{1'b0}};
                    default:  eng_wdata = {DATA_W{1'b0}};
                endcase
            end
            default: begin
                eng_addr    = {dst_r, slot_s};
                own_state_s = 1'b0;
                wr_state_s  = 1'b0;
            end
        endcase
    end

    // The reset term keeps the pins released while _reset is held, even though INIT is a driving state.
    assign busy    = (state_r != ST_IDLE);
    assign done    = (state_r == ST_DONE);
    assign eng_sel = _reset & busy & ~cpu_req & own_state_s;
    assign eng_we  = eng_sel & wr_state_s;

endmodule

// File: tb/tb_dat_sequencer.sv
// Self-checking bench for dat_sequencer: a behavioural DAT RAM, a task-level
// expected-memory model and directed plus randomized command sequences.
module tb_dat_sequencer;
    import dat_pkg::*;

    typedef struct packed {
        logic [14:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        e;
    logic        _reset;
    logic        cpu_req;
    logic        cmd_start;
    logic [1:0]  cmd_op;
    logic [11:0] src_task;
    logic [11:0] dst_task;
    logic [15:0] dat_rdata;
    logic        eng_sel;
    logic [14:0] eng_addr;
    logic [15:0] eng_wdata;
    logic        eng_we;
    logic        busy;
    logic        done;

    logic [15:0] mem     [0:32767];
    logic [15:0] exp_mem [0:32767];
    logic        pl_we;
    logic [14:0] pl_addr;
    logic [15:0] pl_data;
    wr_t         wr_q [$];
    int          done_cnt;
    int          stall_wr;
    logic        req_seq [0:255];
    int          n_checks;
    int          n_fail;

    dat_sequencer dut (
        .e         (e),
        ._reset    (_reset),
        .cpu_req   (cpu_req),
        .cmd_start (cmd_start),
        .cmd_op    (cmd_op),
        .src_task  (src_task),
        .dst_task  (dst_task),
        .dat_rdata (dat_rdata),
        .eng_sel   (eng_sel),
        .eng_addr  (eng_addr),
        .eng_wdata (eng_wdata),
        .eng_we    (eng_we),
        .busy      (busy),
        .done      (done)
    );

    initial e = 1'b0;
    always #5 e = ~e;

    assign dat_rdata = mem[eng_addr];

    initial begin
        done_cnt = 0;
        stall_wr = 0;
    end

    // DAT RAM write port plus write / done monitor.
    always @(posedge e) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (eng_we) mem[eng_addr] <= eng_wdata;
        if (eng_we) begin
            wr_q.push_back({eng_addr, eng_wdata});
            if (cpu_req || !eng_sel) stall_wr <= stall_wr + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    function automatic logic [14:0] ad(input logic [11:0] t, input int i);
        logic [2:0] s;
        s = i[2:0];
        return {t, s};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [11:0] t, input int i, input logic [15:0] d);
        pl_we   = 1'b1;
        pl_addr = ad(t, i);
        pl_data = d;
        exp_mem[ad(t, i)] = d;
        @(posedge e); #1;
        pl_we = 1'b0;
    endtask

    task automatic check_task(input logic [11:0] t, input string tag);
        for (int i = 0; i < 8; i++) chk(tag, {16'h0, mem[ad(t, i)]}, {16'h0, exp_mem[ad(t, i)]});
    endtask

    // Expected result of a whole command over one task, straight from the op definitions.
    task automatic model_op(input logic [1:0] op, input logic [11:0] s, input logic [11:0] d, input int nslots);
        logic [15:0] tmp [0:7];
        for (int i = 0; i < 8; i++) tmp[i] = exp_mem[ad(s, i)];
        for (int i = 0; i < nslots; i++) begin
            if (op == OP_COPY) exp_mem[ad(d, i)] = tmp[i];
            else if (op == OP_FILL) exp_mem[ad(d, i)] = 16'(i);
            else exp_mem[ad(d, i)] = 16'h0000;
        end
    endtask

    // Build the CPU-request pattern; expected busy length = cycles to collect the grants (+DONE).
    task automatic plan_seq(input int mode, input int need, input bit has_done, output int exp_len);
        int grants;
        grants  = 0;
        exp_len = -1;
        for (int j = 0; j < 256; j++) begin
            case (mode)
                0:       req_seq[j] = 1'b0;
                1:       req_seq[j] = (j % 2 == 0);
                default: req_seq[j] = ($urandom_range(0, 9) < 4);
            endcase
        end
        for (int j = 0; j < 256; j++) begin
            if (exp_len < 0) begin
                if (!req_seq[j]) grants++;
                if (grants == need) exp_len = j + 1 + (has_done ? 1 : 0);
            end
        end
    endtask

    task automatic run_cycles(input int stray_a, input int stray_b, input logic [11:0] stray_t, output int len);
        len = -1;
        for (int j = 0; j < 250; j++) begin
            cpu_req = req_seq[j];
            if (j == stray_a || j == stray_b) begin
                cmd_start = 1'b1;
                cmd_op    = OP_CLEAR;
                src_task  = stray_t;
                dst_task  = stray_t;
            end
            @(negedge e);
            if (!busy) begin
                len = j;
                break;
            end
            @(posedge e); #1;
            cmd_start = 1'b0;
        end
        cpu_req   = 1'b0;
        cmd_start = 1'b0;
    endtask

    task automatic check_writes(input int wb, input logic [11:0] d, input string tag);
        chk({tag, ".nwr"}, wr_q.size() - wb, 32'd8);
        if (wr_q.size() - wb == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk({tag, ".wa"}, {17'h0, wr_q[wb+i].addr}, {17'h0, ad(d, i)});
                chk({tag, ".wd"}, {16'h0, wr_q[wb+i].data}, {16'h0, exp_mem[ad(d, i)]});
            end
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [11:0] s, input logic [11:0] d, input int mode,
                          input int stray_a, input int stray_b, input logic [11:0] stray_t, input string tag);
        int exp_len, len, wb, db, sb;
        plan_seq(mode, (op == OP_COPY) ? 16 : 8, 1'b1, exp_len);
        wb = wr_q.size();
        db = done_cnt;
        sb = stall_wr;
        cmd_start = 1'b1;
        cmd_op    = op;
        src_task  = s;
        dst_task  = d;
        cpu_req   = 1'b0;
        @(posedge e); #1;
        cmd_start = 1'b0;
        run_cycles(stray_a, stray_b, stray_t, len);
        chk({tag, ".busy_len"}, len, exp_len);
        chk({tag, ".done_cnt"}, done_cnt - db, 32'd1);
        chk({tag, ".stall_wr"}, stall_wr - sb, 32'd0);
        model_op(op, s, d, 8);
        check_writes(wb, d, tag);
        check_task(d, {tag, ".mem"});
    endtask

    task automatic run_init(input string tag);
        int exp_len, len, wb;
        plan_seq(0, 8, 1'b0, exp_len);
        wb = wr_q.size();
        run_cycles(-1, -1, 12'h000, len);
        chk({tag, ".busy_len"}, len, exp_len);
        model_op(OP_FILL, 12'h000, 12'h000, 8);
        check_writes(wb, 12'h000, tag);
        check_task(12'h000, {tag, ".mem"});
    endtask

    initial begin
        int db, wb, len;
        logic [11:0] rs, rd;
        n_checks  = 0;
        n_fail    = 0;
        _reset    = 1'b0;
        cpu_req   = 1'b0;
        cmd_start = 1'b0;
        cmd_op    = OP_COPY;
        src_task  = 12'h000;
        dst_task  = 12'h000;
        pl_we     = 1'b0;
        pl_addr   = 15'h0000;
        pl_data   = 16'h0000;

        // Reset state and identity load of task 0.
        repeat (2) @(posedge e);
        @(negedge e);
        chk("rst.busy", {31'h0, busy}, 32'd1);
        chk("rst.done", {31'h0, done}, 32'd0);
        chk("rst.we", {31'h0, eng_we}, 32'd0);
        chk("rst.sel", {31'h0, eng_sel}, 32'd0);
        @(posedge e); #1;
        _reset = 1'b1;
        run_init("init");
        chk("init.done_cnt", done_cnt, 32'd0);

        // Copy 5 -> 0x123 with stray commands mid-copy and on the DONE cycle.
        for (int i = 0; i < 8; i++) preload(12'h005, i, 16'h0010 + 16'(i));
        for (int i = 0; i < 8; i++) preload(12'h123, i, 16'($urandom));
        for (int i = 0; i < 8; i++) preload(12'h0AA, i, 16'($urandom) | 16'h0001);
        do_cmd(OP_COPY, 12'h005, 12'h123, 0, 4, 16, 12'h0AA, "copy5");
        check_task(12'h0AA, "copy5.stray_task");
        check_task(12'h005, "copy5.src");

        // Reserved opcode in IDLE is ignored.
        wb = wr_q.size();
        db = done_cnt;
        cmd_start = 1'b1;
        cmd_op    = OP_RSVD;
        src_task  = 12'h007;
        dst_task  = 12'h0AA;
        @(posedge e); #1;
        cmd_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge e);
            chk("rsvd.busy", {31'h0, busy}, 32'd0);
            @(posedge e); #1;
        end
        chk("rsvd.nwr", wr_q.size() - wb, 32'd0);
        chk("rsvd.done_cnt", done_cnt - db, 32'd0);
        check_task(12'h0AA, "rsvd.mem");

        // Clear with cpu_req toggling, then randomized copies and a max-task fill.
        do_cmd(OP_CLEAR, 12'h000, 12'h123, 1, -1, -1, 12'h000, "clear");
        rs = 12'h200 | 12'($urandom_range(0, 255));
        rd = 12'h300 | 12'($urandom_range(0, 255));
        for (int i = 0; i < 8; i++) preload(rs, i, 16'($urandom));
        for (int i = 0; i < 8; i++) preload(rd, i, 16'($urandom));
        do_cmd(OP_COPY, rs, rd, 2, -1, -1, 12'h000, "rcopy");
        for (int i = 0; i < 8; i++) preload(rd, i, 16'($urandom));
        do_cmd(OP_COPY, rd, rd, 2, -1, -1, 12'h000, "selfcopy");
        for (int i = 0; i < 8; i++) preload(12'hFFF, i, 16'($urandom) | 16'h8000);
        do_cmd(OP_FILL, 12'h000, 12'hFFF, 2, -1, -1, 12'h000, "fillmax");
        check_task(12'h000, "fillmax.task0");

        // Reset during slot 3 of a copy: abort, INIT reruns, partial copy kept.
        for (int i = 0; i < 8; i++) preload(12'h000, i, 16'($urandom) | 16'h0100);
        for (int i = 0; i < 8; i++) preload(12'h123, i, 16'($urandom) | 16'h0100);
        wb = wr_q.size();
        db = done_cnt;
        cmd_start = 1'b1;
        cmd_op    = OP_COPY;
        src_task  = 12'h005;
        dst_task  = 12'h123;
        @(posedge e); #1;
        cmd_start = 1'b0;
        repeat (6) begin
            @(posedge e); #1;
        end
        chk("abort.nwr_before", wr_q.size() - wb, 32'd3);
        _reset = 1'b0;
        #1;
        chk("abort.busy", {31'h0, busy}, 32'd1);
        chk("abort.sel", {31'h0, eng_sel}, 32'd0);
        chk("abort.we", {31'h0, eng_we}, 32'd0);
        chk("abort.done", {31'h0, done}, 32'd0);
        repeat (2) @(posedge e);
        #1;
        _reset = 1'b1;
        model_op(OP_COPY, 12'h005, 12'h123, 3);
        run_init("reinit");
        chk("abort.done_cnt", done_cnt - db, 32'd0);
        check_task(12'h123, "abort.dst");

        @(negedge e);
        chk("stall_wr_total", stall_wr, 32'd0);
        len = n_checks;
        $display("End of test - %0d assertions evaluated, %0d failures", len, n_fail);
        $finish;
    end

endmodule
